// File: rtl/teachee_packetizer_pkg.sv
// packetizer_pkg: shared types and constants for the ADC sample packetizer.
package packetizer_pkg;
    typedef enum logic [2:0] {IDLE, HEADER, SEQ, PAYLOAD, CHK} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int BYTES_PER_SAMPLE = 4;
    typedef struct packed {
        logic [15:0] voltage;
        logic [15:0] current;
    } sample_t;
    // Big-endian order on the wire: V high, V low, I high, I low.
    function automatic logic [7:0] sample_byte(sample_t s, logic [1:0] idx);
        return idx == 2'd0 ? s.voltage[15:8] : idx == 2'd1 ? s.voltage[7:0] :
               idx == 2'd2 ? s.current[15:8] : s.current[7:0];
    endfunction
endpackage

// File: rtl/teachee_packetizer_sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO; also exposes the entry behind the head
// so a consumer can register the next word in the same cycle it pops.
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic [WIDTH-1:0]       second,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_en;
    assign full   = count == CW'(DEPTH);
    assign empty  = count == '0;
    assign wr_en  = push && !full;
    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + AW'(1)];
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(wr_en) - CW'(pop);
        end
endmodule

// File: rtl/teachee_packetizer.sv
// teachee_packetizer: frames buffered voltage/current samples into sync/SEQ/payload/CHK
// byte packets on a valid/ready stream toward the FT232H writer.
module teachee_packetizer
    import packetizer_pkg::*;
#(
    parameter int SAMPLES_PER_PACKET = 4,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [15:0] sample_voltage,
    input  logic [15:0] sample_current,
    output logic [7:0]  write_data,
    output logic        write_valid,
    input  logic        write_ready,
    output logic [15:0] drop_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(SAMPLES_PER_PACKET + 1);
    localparam logic [CW-1:0] N_CNT     = CW'(SAMPLES_PER_PACKET);
    localparam logic [SW-1:0] LAST      = SW'(SAMPLES_PER_PACKET - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_SAMPLE - 1);

    state_t state;
    sample_t head, second;
    logic full, empty, xfer, pop;
    logic [CW-1:0] count;
    logic [7:0] seq, acc;
    logic [1:0] byte_idx;
    logic [SW-1:0] sample_idx;

    assign xfer = write_valid && write_ready;
    assign pop  = state == PAYLOAD && xfer && byte_idx == LAST_BYTE && !empty;

    sample_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (sample_valid),
        .pop     (pop),
        .din     ({sample_voltage, sample_current}),
        .head    (head),
        .second  (second),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) drop_count <= '0;
        else if (sample_valid && full && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;

    // write_data always holds the byte for the current state, so the next byte is
    // computed on each transfer; a pop therefore reads the entry behind the head.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state       <= IDLE;
            write_valid <= 1'b0;
            write_data  <= 8'h00;
            seq         <= 8'h00;
            acc         <= 8'h00;
            byte_idx    <= 2'd0;
            sample_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (count >= N_CNT) begin
                    state       <= HEADER;
                    write_valid <= 1'b1;
                    write_data  <= SYNC_BYTE;
                end
                HEADER: begin
                    acc <= 8'h00;
                    if (xfer) begin
                        state      <= SEQ;
                        write_data <= seq;
                    end
                end
                SEQ: if (xfer) begin
                    acc        <= acc + write_data;
                    state      <= PAYLOAD;
                    byte_idx   <= 2'd0;
                    sample_idx <= '0;
                    write_data <= sample_byte(head, 2'd0);
                end
                PAYLOAD: if (xfer) begin
                    acc      <= acc + write_data;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx != LAST_BYTE) write_data <= sample_byte(head, byte_idx + 2'd1);
                    else if (sample_idx == LAST) begin
                        state      <= CHK;
                        write_data <= acc + write_data;
                    end else begin
                        sample_idx <= sample_idx + SW'(1);
                        write_data <= sample_byte(second, 2'd0);
                    end
                end
                CHK: if (xfer) begin
                    seq         <= seq + 8'd1;
                    state       <= IDLE;
                    write_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_teachee_packetizer.sv
// tb_teachee_packetizer: vector table plus byte scoreboard for the sample packetizer.
module tb_teachee_packetizer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_voltage = '0;
    logic [15:0] sample_current = '0;
    logic [7:0]  write_data;
    logic        write_valid;
    logic        write_ready = 1'b0;
    logic [15:0] drop_count;

    typedef struct packed {
        logic [15:0] v;
        logic [15:0] i;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [4];

    logic [7:0]  exp_q [$];
    logic [31:0] pend [$];
    logic [7:0]  model_seq = 8'h00;
    logic [7:0]  last_seq = 8'h00;
    logic [7:0]  hold_data = 8'h00;
    logic        hold_pend = 1'b0;
    int          pos = 0;
    int          xfer_total = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    teachee_packetizer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_valid   (sample_valid),
        .sample_voltage (sample_voltage),
        .sample_current (sample_current),
        .write_data     (write_data),
        .write_valid    (write_valid),
        .write_ready    (write_ready),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted byte is checked against the queue; stalled bytes must hold.
    always @(negedge clk) begin
        if (!reset_n) begin
            pos = 0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 32'(write_valid), 32'd1);
                chk("hold_data", 32'(write_data), 32'(hold_data));
            end
            hold_pend = write_valid && !write_ready;
            hold_data = write_data;
            if (write_valid && write_ready) begin
                xfer_total++;
                if (pos == 1) last_seq = write_data;
                if (exp_q.size() == 0) chk("unexpected_byte", 32'(write_data), 32'h100);
                else chk("byte", 32'(write_data), 32'(exp_q.pop_front()));
                pos = (pos == 18) ? 0 : pos + 1;
            end
        end
    end

    task automatic send(input logic [15:0] v, input logic [15:0] i);
        @(posedge clk);
        #1 sample_valid = 1'b1;
        sample_voltage = v;
        sample_current = i;
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    // Reference model: queues the full expected packet once four accepted samples exist.
    task automatic send_m(input logic [15:0] v, input logic [15:0] i, input bit accept);
        logic [7:0] sum, x;
        if (accept) begin
            pend.push_back({v, i});
            if (pend.size() == 4) begin
                exp_q.push_back(8'hA5);
                exp_q.push_back(model_seq);
                sum = model_seq;
                for (int j = 0; j < 4; j++)
                    for (int b = 3; b >= 0; b--) begin
                        x = pend[j][8*b +: 8];
                        exp_q.push_back(x);
                        sum = sum + x;
                    end
                exp_q.push_back(sum);
                model_seq = model_seq + 8'd1;
                pend.delete();
            end
        end
        send(v, i);
    endtask

    task automatic push_table();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 4; b++) exp_q.push_back(tbl[k].exp[31-8*b -: 8]);
        exp_q.push_back(8'hBD);
    endtask

    task automatic drain(input bit rnd, input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(posedge clk);
            #1 write_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            k++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        write_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        exp_q.delete();
        pend.delete();
        model_seq = 8'h00;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        tbl[0] = '{16'h1234, 16'hABCD, 32'h1234ABCD};
        tbl[1] = '{16'h0001, 16'h0002, 32'h00010002};
        tbl[2] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
        tbl[3] = '{16'h00FF, 16'hFF00, 32'h00FFFF00};

        repeat (2) @(posedge clk);
        #1 chk("reset_valid", 32'(write_valid), 32'd0);
        chk("reset_data", 32'(write_data), 32'd0);
        chk("reset_drop", 32'(drop_count), 32'd0);
        #2 reset_n = 1'b1;

        write_ready = 1'b1;
        for (int k = 0; k < 3; k++) send(tbl[k].v, tbl[k].i);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_valid", 32'(write_valid), 32'd0);
        end
        chk("idle_drop", 32'(drop_count), 32'd0);

        do_reset();
        write_ready = 1'b1;
        push_table();
        for (int k = 0; k < 4; k++) send(tbl[k].v, tbl[k].i);
        @(negedge clk);
        chk("basic_latency", 32'(write_valid), 32'd0);
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            chk("basic_contig", 32'(write_valid), 32'd1);
        end
        @(negedge clk);
        chk("basic_gap", 32'(write_valid), 32'd0);
        chk("basic_left", 32'(exp_q.size()), 32'd0);

        do_reset();
        write_ready = 1'b0;
        push_table();
        for (int k = 0; k < 4; k++) send(tbl[k].v, tbl[k].i);
        drain(1'b1, 2000);
        model_seq = 8'h01;

        write_ready = 1'b0;
        for (int k = 0; k < 20; k++) send_m(16'h1000 + 16'(k), 16'h2000 + 16'(k), k < 16);
        repeat (2) @(posedge clk);
        chk("overflow_drop", 32'(drop_count), 32'd4);
        drain(1'b0, 400);

        write_ready = 1'b1;
        start = xfer_total;
        for (int k = 0; k < 4; k++) send_m(16'($urandom), 16'($urandom), 1'b1);
        for (int k = 0; k < 100 && xfer_total < start + 5; k++) @(negedge clk);
        chk("mid_xfers", 32'(xfer_total - start), 32'd5);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("mid_valid", 32'(write_valid), 32'd0);
        chk("mid_drop", 32'(drop_count), 32'd0);
        chk("mid_data", 32'(write_data), 32'd0);
        exp_q.delete();
        pend.delete();
        model_seq = 8'h00;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        last_seq = 8'h55;
        for (int k = 0; k < 4; k++) send_m(16'($urandom), 16'($urandom), 1'b1);
        drain(1'b0, 200);
        chk("mid_restart_seq", 32'(last_seq), 32'h00);

        do_reset();
        write_ready = 1'b1;
        for (int p = 1; p <= 257; p++) begin
            for (int k = 0; k < 4; k++) send_m(16'($urandom), 16'($urandom), 1'b1);
            drain(1'b0, 200);
            if (p == 256) chk("seq_256", 32'(last_seq), 32'hFF);
            if (p == 257) chk("seq_257", 32'(last_seq), 32'h00);
        end
        chk("wrap_drop", 32'(drop_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
